// File: rtl/lut_square_product_module_if.sv
// Handshake bus for the quarter-square multiplier back end: sum/difference in, product out.
interface lut_square_product_module_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [W:0]     i1_in;
  logic [W:0]     i2_in;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  modport master (
    output in_valid, i1_in, i2_in, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, i1_in, i2_in, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/lut_square_product_module.sv
// Quarter-square multiplier back end: abs -> ROM lookup -> subtract, three stages
// sharing a single advance enable so that backpressure stalls the whole pipe.
module lut_square_product_module #(
  parameter int W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  lut_square_product_module_if.slave  bus
);
  localparam int QW = 2 * W - 1;
  localparam int PW = 2 * W;
  localparam int N  = 1 << W;

  // Q[x] = floor(x*x/4) for x = 0..2^W, elaborated as constants
  logic [QW-1:0] q_rom [0:N];

  generate
    for (genvar gi = 0; gi <= N; gi++) begin : g_rom
      assign q_rom[gi] = QW'((gi * gi) / 4);
    end
  endgenerate

  logic          adv;
  logic [W:0]    u1_next, u2_next;
  logic [W:0]    u1_reg, u2_reg;
  logic          v1_reg;
  logic [QW-1:0] q1_reg, q2_reg;
  logic          v2_reg;
  logic          out_valid_reg;
  logic [PW-1:0] product_reg;

  assign adv = !out_valid_reg || bus.out_ready;

  // -2^W has no positive W+1-bit twin, but its negation reads as 2^W unsigned
  assign u1_next = bus.i1_in[W] ? -bus.i1_in : bus.i1_in;
  assign u2_next = bus.i2_in[W] ? -bus.i2_in : bus.i2_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u1_reg        <= '0;
      u2_reg        <= '0;
      v1_reg        <= 1'b0;
      q1_reg        <= '0;
      q2_reg        <= '0;
      v2_reg        <= 1'b0;
      out_valid_reg <= 1'b0;
      product_reg   <= '0;
    end else if (adv) begin
      u1_reg        <= u1_next;
      u2_reg        <= u2_next;
      v1_reg        <= bus.in_valid;
      q1_reg        <= q_rom[u1_reg];
      q2_reg        <= q_rom[u2_reg];
      v2_reg        <= v1_reg;
      out_valid_reg <= v2_reg;
      // s and d share parity, so the two floors cancel exactly
      if (v2_reg) begin
        product_reg <= {1'b0, q1_reg} - {1'b0, q2_reg};
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_reg;
  assign bus.product   = product_reg;
endmodule

// File: tb/tb_lut_square_product_module.sv
// Directed and exhaustive checks of the quarter-square multiplier back end.
module tb_lut_square_product_module;
  localparam int W  = 8;
  localparam int IW = W + 1;
  localparam int PW = 2 * W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  lut_square_product_module_if #(.W(W)) bus();

  lut_square_product_module #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic drive_pair(input int a, input int b, input logic vld);
    bus.i1_in    = IW'(a + b);
    bus.i2_in    = IW'(a - b);
    bus.in_valid = vld;
  endtask

  task automatic test_reset();
    drive_pair(0, 0, 1'b0);
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.product !== '0) begin failures++; $display("FAIL reset_product: got %0d expected 0", bus.product); end
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle: got %b expected 0", bus.out_valid); end
    $display("reset: out_valid=%b product=%0d", bus.out_valid, bus.product);
  endtask

  task automatic test_single();
    logic exp_v;
    @(negedge clk);
    drive_pair(3, 5, 1'b1);
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready: got %b expected 1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      exp_v = (c == 3);
      checks++;
      if (bus.out_valid !== exp_v) begin failures++; $display("FAIL single_latency_c%0d: got %b expected %b", c, bus.out_valid, exp_v); end
      if (c == 3) begin
        checks++;
        if (bus.product !== PW'(15)) begin failures++; $display("FAIL single_product: got %0d expected 15", $signed(bus.product)); end
        $display("single: a=3 b=5 product=%0d", $signed(bus.product));
      end
    end
  endtask

  task automatic test_corners();
    int a_t [5] = '{-128, -128, 127, 0, -1};
    int b_t [5] = '{-128, 127, 127, -77, 1};
    int e_t [5] = '{16384, -16256, 16129, 0, -1};
    logic [PW-1:0] e;
    bus.out_ready = 1'b1;
    for (int it = 0; it < 10; it++) begin
      @(negedge clk);
      if (it < 5) drive_pair(a_t[it], b_t[it], 1'b1);
      else        drive_pair(0, 0, 1'b0);
      #1;
      if (it >= 3 && it < 8) begin
        e = PW'(e_t[it-3]);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.product !== e) begin
          failures++;
          $display("FAIL corner_%0d: got valid=%b product=%0d expected valid=1 product=%0d",
                   it - 3, bus.out_valid, $signed(bus.product), $signed(e));
        end
        $display("corner: a=%0d b=%0d product=%0d", a_t[it-3], b_t[it-3], $signed(bus.product));
      end else if (it == 8) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL corner_drain: got %b expected 0", bus.out_valid); end
      end
    end
  endtask

  task automatic test_streaming();
    int exp_q [$];
    int got = 0, first = -1, last = -1, a, b;
    logic [PW-1:0] e;
    bus.out_ready = 1'b1;
    for (int it = 0; it < 70; it++) begin
      @(negedge clk);
      a = it * 3 - 96;
      b = 100 - it * 3;
      if (it < 64) drive_pair(a, b, 1'b1);
      else         drive_pair(0, 0, 1'b0);
      #1;
      if (it < 64) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready_%0d: got %b expected 1", it, bus.in_ready); end
      end
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL stream_extra: got product=%0d expected no output", $signed(bus.product));
        end else begin
          e = PW'(exp_q.pop_front());
          if (bus.product !== e) begin failures++; $display("FAIL stream_%0d: got %0d expected %0d", got, $signed(bus.product), $signed(e)); end
          $display("stream: #%0d product=%0d", got, $signed(bus.product));
        end
        if (first < 0) first = it;
        last = it;
        got++;
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(a * b);
    end
    checks++;
    if (got !== 64) begin failures++; $display("FAIL stream_count: got %0d expected 64", got); end
    checks++;
    if (last - first !== 63) begin failures++; $display("FAIL stream_gapless: got span %0d expected 63", last - first); end
  endtask

  task automatic test_stall();
    int exp_q [$];
    int got = 0, k = 0, a, b;
    logic frz_v;
    logic [PW-1:0] frz_p, e;
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      a = k * 7 - 70;
      b = 40 - k * 5;
      drive_pair(a, b, k < 20);
      bus.out_ready = !(it >= 6 && it <= 10);
      #1;
      if (it >= 3 && got < 20) begin
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall_gap_%0d: got out_valid=%b expected 1", it, bus.out_valid); end
      end
      if (it == 6) begin
        frz_v = bus.out_valid;
        frz_p = bus.product;
      end
      if (it >= 7 && it <= 11) begin
        checks++;
        if (bus.out_valid !== frz_v || bus.product !== frz_p) begin
          failures++;
          $display("FAIL stall_frozen_%0d: got %b/%0d expected %b/%0d", it, bus.out_valid, $signed(bus.product), frz_v, $signed(frz_p));
        end
      end
      if (it >= 6 && it <= 10) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready_%0d: got %b expected 0", it, bus.in_ready); end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL stall_extra: got product=%0d expected no output", $signed(bus.product));
        end else begin
          e = PW'(exp_q.pop_front());
          if (bus.product !== e) begin failures++; $display("FAIL stall_%0d: got %0d expected %0d", got, $signed(bus.product), $signed(e)); end
          $display("stall: #%0d product=%0d", got, $signed(bus.product));
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(a * b);
        k++;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (got !== 20 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL stall_count: got %0d outputs, %0d pending expected 20 outputs, 0 pending", got, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    int a_t [3] = '{100, -5, 10};
    int b_t [3] = '{1, 7, 10};
    bus.out_ready = 1'b1;
    for (int it = 0; it < 3; it++) begin
      @(negedge clk);
      drive_pair(a_t[it], b_t[it], 1'b1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.product !== PW'(100)) begin
      failures++;
      $display("FAIL midflight_pre: got %b/%0d expected 1/100", bus.out_valid, $signed(bus.product));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.product !== '0) begin
      failures++;
      $display("FAIL midflight_flush: got %b/%0d expected 0/0", bus.out_valid, $signed(bus.product));
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int it = 0; it < 6; it++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midflight_stale_%0d: got %b expected 0", it, bus.out_valid); end
    end
    drive_pair(-7, 9, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.product !== PW'(-63)) begin
      failures++;
      $display("FAIL midflight_resume: got %b/%0d expected 1/-63", bus.out_valid, $signed(bus.product));
    end
    $display("midflight: resume product=%0d", $signed(bus.product));
  endtask

  task automatic test_exhaustive();
    int exp_q [$];
    int k = 0, got = 0, cyc = 0, bad = 0, a, b;
    logic [PW-1:0] e;
    while (got < 65536 && cyc < 80000) begin
      @(negedge clk);
      a = (k >> 8) - 128;
      b = (k & 255) - 128;
      drive_pair(a, b, (k < 65536) && ($urandom_range(0, 31) != 0));
      bus.out_ready = ($urandom_range(0, 31) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          bad++;
          $display("FAIL exh_extra: got product=%0d expected no output", $signed(bus.product));
        end else begin
          e = PW'(exp_q.pop_front());
          if (bus.product !== e) begin
            failures++;
            bad++;
            $display("FAIL exh_%0d: got %0d expected %0d", got, $signed(bus.product), $signed(e));
          end
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(a * b);
        k++;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (got !== 65536) begin failures++; $display("FAIL exh_count: got %0d expected 65536 (cycles %0d)", got, cyc); end
    $display("exhaustive: %0d products, %0d mismatched, %0d cycles", got, bad, cyc);
  endtask

  initial begin
    test_reset();
    test_single();
    test_corners();
    test_streaming();
    test_stall();
    test_reset_midflight();
    test_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
